// File: rtl/clock_ratio_meter.sv
// clock_ratio_meter
// Measures a slow periodic signal (typically a divided clock) in system-clock
// cycles. It reports the high time, low time and period of the last completed
// period, flags lock when two consecutive periods match, and flags a stuck
// signal when no edge arrives for timeout_value cycles.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          synchronous active-high reset
//   sig_in       signal under measurement, asynchronous to clk
//   high_count   cycles high in the last completed period
//   low_count    cycles low in the last completed period
//   period_count high_count + low_count of the last completed period
//   meas_valid   one-cycle pulse when the counts update
//   locked       two consecutive periods had identical length
//   stuck        no edge seen for timeout_value cycles
module clock_ratio_meter #(
    parameter int cnt_width     = 16,
    parameter int timeout_value = 65535,
    parameter int sync_stages   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sig_in,
    output logic [cnt_width-1:0] high_count,
    output logic [cnt_width-1:0] low_count,
    output logic [cnt_width:0]   period_count,
    output logic                 meas_valid,
    output logic                 locked,
    output logic                 stuck
);

    localparam logic [cnt_width-1:0] CNT_MAX = '1;
    localparam logic [cnt_width-1:0] TIMEOUT = cnt_width'(timeout_value);
    localparam int                   WARM_W  = $clog2(sync_stages + 2);
    localparam logic [WARM_W-1:0]    WARM_DONE = WARM_W'(sync_stages + 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t               state, next_state;
    logic [sync_stages-1:0] sync_q;
    logic                 sig_s, prev;
    logic [WARM_W-1:0]    warm;
    logic [cnt_width-1:0] counter;
    logic [cnt_width:0]   prev_period;
    logic [cnt_width:0]   new_period;
    logic                 unmasked, rise, fall, edge_any, timeout_hit;
    logic                 cap_high, cap_low;

    assign sig_s = sync_q[sync_stages-1];

    // Edges are ignored until the synchronizer and prev flop hold real
    // samples, so a level present through reset is not seen as an edge.
    assign unmasked    = (warm == WARM_DONE);
    assign rise        = unmasked & sig_s & ~prev;
    assign fall        = unmasked & ~sig_s & prev;
    assign edge_any    = rise | fall;
    // An edge on the timeout cycle wins: the timeout only fires edge-free.
    assign timeout_hit = ~edge_any & (counter == TIMEOUT);

    // On the closing rise the counter holds the low time of this period.
    assign new_period  = {1'b0, high_count} + {1'b0, counter};

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        if (timeout_hit) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (rise) next_state = HIGH;
                HIGH:    if (fall) next_state = LOW;
                LOW:     if (rise) next_state = HIGH;
                default: next_state = IDLE;
            endcase
        end
    end

    // Output decode: capture strobes for the measurement registers
    always_comb begin
        cap_high = 1'b0;
        cap_low  = 1'b0;
        case (state)
            HIGH:    cap_high = fall;
            LOW:     cap_low  = rise;
            default: ;
        endcase
    end

    // Synchronizer, edge history and warm-up
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev   <= 1'b0;
            warm   <= '0;
        end else begin
            sync_q <= {sync_q[sync_stages-2:0], sig_in};
            prev   <= sig_s;
            if (!unmasked) warm <= warm + WARM_W'(1);
        end
    end

    // Edge-to-edge counter and measurement registers
    always_ff @(posedge clk) begin
        if (rst) begin
            counter      <= '0;
            high_count   <= '0;
            low_count    <= '0;
            period_count <= '0;
            prev_period  <= '0;
            meas_valid   <= 1'b0;
            locked       <= 1'b0;
            stuck        <= 1'b0;
        end else begin
            if (edge_any)                counter <= cnt_width'(1);
            else if (counter != CNT_MAX) counter <= counter + cnt_width'(1);

            meas_valid <= cap_low;

            if (cap_high) high_count <= counter;

            if (cap_low) begin
                low_count    <= counter;
                period_count <= new_period;
                prev_period  <= new_period;
                // prev_period is zero after reset or timeout, so the first
                // period seen from IDLE can never claim lock.
                locked       <= (new_period == prev_period) && (prev_period != '0);
            end

            if (timeout_hit) begin
                stuck       <= 1'b1;
                locked      <= 1'b0;
                prev_period <= '0;
            end else if (edge_any) begin
                stuck <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clock_ratio_meter.sv
module tb_clock_ratio_meter;

    localparam int CW = 16;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          sig_in;
    logic [CW-1:0] high_count, low_count;
    logic [CW:0]   period_count;
    logic          meas_valid, locked, stuck;

    int checks = 0;
    int errors = 0;

    clock_ratio_meter #(.cnt_width(CW), .timeout_value(TO), .sync_stages(2)) dut (
        .clk(clk), .rst(rst), .sig_in(sig_in),
        .high_count(high_count), .low_count(low_count), .period_count(period_count),
        .meas_valid(meas_valid), .locked(locked), .stuck(stuck)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h; int l;
        int eh; int el; int ep; int elk;
    } vec_t;

    typedef struct {
        int hc; int lc; int pc; int lk;
    } rec_t;

    rec_t q[$];

    // Record every measurement pulse, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst && meas_valid)
            q.push_back('{int'(high_count), int'(low_count), int'(period_count), int'(locked)});
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Hold sig_in at v for n clk cycles; called and returns on a negedge.
    task automatic drive(input logic v, input int n);
        sig_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_rec(input string nm, input int idx, input int eh, input int el,
                           input int ep, input int elk);
        if (idx < q.size()) begin
            chk({nm, ".high"},   q[idx].hc, eh);
            chk({nm, ".low"},    q[idx].lc, el);
            chk({nm, ".period"}, q[idx].pc, ep);
            chk({nm, ".locked"}, q[idx].lk, elk);
        end else begin
            chk({nm, ".present"}, q.size(), idx + 1);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".high"},   high_count, 0);
        chk({nm, ".low"},    low_count, 0);
        chk({nm, ".period"}, period_count, 0);
        chk({nm, ".mv"},     meas_valid, 0);
        chk({nm, ".locked"}, locked, 0);
        chk({nm, ".stuck"},  stuck, 0);
    endtask

    initial begin
        vec_t vecs[10];
        int base;

        vecs[0] = '{2, 2, 2, 2, 4, 0};   // first period from IDLE never locks
        vecs[1] = '{2, 2, 2, 2, 4, 1};
        vecs[2] = '{2, 2, 2, 2, 4, 1};
        vecs[3] = '{5, 3, 5, 3, 8, 0};
        vecs[4] = '{5, 3, 5, 3, 8, 1};
        vecs[5] = '{6, 2, 6, 2, 8, 1};   // same period, different duty
        vecs[6] = '{5, 5, 5, 5, 10, 0};
        vecs[7] = '{5, 5, 5, 5, 10, 1};
        vecs[8] = '{1, 1, 1, 1, 2, 0};   // minimum high/low time
        vecs[9] = '{1, 1, 1, 1, 2, 1};

        rst = 1'b1;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        drive(1'b0, 5);

        // Table: each period's measurement lands at the next rise.
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].h);
            drive(1'b0, vecs[i].l);
        end
        drive(1'b1, 1);
        // Low long enough to time out (counter reaches 20 after the fall).
        drive(1'b0, 25);
        chk("table.count", q.size(), 10);
        foreach (vecs[i])
            chk_rec($sformatf("vec%0d", i), i, vecs[i].eh, vecs[i].el, vecs[i].ep, vecs[i].elk);
        chk("to.stuck",  stuck, 1);
        chk("to.locked", locked, 0);
        chk("to.high",   high_count, 1);
        chk("to.low",    low_count, 1);
        chk("to.period", period_count, 2);

        // Rise clears stuck; restart from IDLE. Low of exactly 20 puts the
        // closing edge on the timeout cycle, where the edge must win.
        base = q.size();
        drive(1'b1, 3);
        chk("restart.stuck", stuck, 0);
        chk("restart.no_mv", q.size(), base);
        drive(1'b0, 20);
        drive(1'b1, 4);
        chk("edge_wins.count", q.size(), base + 1);
        chk_rec("edge_wins", base, 3, 20, 23, 0);
        chk("edge_wins.stuck", stuck, 0);

        // Reset in the middle of a low phase discards the partial period.
        drive(1'b0, 5);
        base = q.size();
        rst = 1'b1;
        @(negedge clk);
        chk_zero("midrst");

        // sig_in high through reset: no false rise during warm-up.
        sig_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 6);
        drive(1'b0, 4);
        drive(1'b1, 4);
        drive(1'b0, 4);
        chk("warm.no_mv", q.size(), base);
        // Closing rise: meas_valid exactly sync_stages+1 cycles later.
        sig_in = 1'b1;
        @(negedge clk);
        chk("lat.c1", meas_valid, 0);
        @(negedge clk);
        chk("lat.c2", meas_valid, 0);
        @(negedge clk);
        chk("lat.c3", meas_valid, 1);
        @(negedge clk);
        chk("lat.c4", meas_valid, 0);
        chk_rec("warm", base, 4, 4, 8, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_ratio_meter.md
Name: clock_ratio_meter

Overview:
- Measures a slow periodic signal, typically a divided clock from the clock divider, against the system clock.
- Reports high time, low time and period in system-clock cycles.
- Flags lock when consecutive periods match, and flags a stuck signal on timeout.
- Sits beside the VGA timing logic as a self-check that the divided pixel/derived clocks run at the intended ratio.

Parameters:
- cnt_width, 16, width of the high/low counters and count outputs.
- timeout_value, 65535, cycles without an edge before stuck is raised; must be ≤ 2^cnt_width-1 and ≥ 2.
- sync_stages, 2, flip-flops in the input synchronizer (≥ 2).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- sig_in  input  1  signal under measurement; asynchronous to clk.
- high_count  output  cnt_width  cycles sig was high in the last completed period.
- low_count  output  cnt_width  cycles sig was low in the last completed period.
- period_count  output  cnt_width+1  high_count+low_count of the last completed period.
- meas_valid  output  1  one-cycle pulse when high/low/period update.
- locked  output  1  two consecutive periods had identical period_count.
- stuck  output  1  no edge seen for timeout_value cycles.

Behaviour:
- Reset (synchronous, dominates every other event):
  - All outputs are 0. Synchronizer flops and prev flop are 0.
  - State goes to IDLE. Counter, prev_period and warm-up counter are 0.
- Synchronizer and edge detect:
  - sig_in passes through sync_stages flops to give sig_s. prev holds sig_s delayed one cycle.
  - rise = sig_s & ~prev. fall = ~sig_s & prev.
  - Edges are masked for the first sync_stages+1 cycles after rst deasserts (warm-up counter). This means a sig_in held high through reset creates no false rise.
- Counter:
  - On any unmasked edge, counter <= 1.
  - Otherwise counter <= counter+1, saturating at 2^cnt_width-1.
  - On an edge cycle, the counter value equals the cycles since the previous edge.
- States:
  - IDLE: ignore fall. On rise → HIGH.
  - HIGH: on fall → high_count <= counter, go to LOW.
  - LOW: on rise → low_count <= counter, period_count <= high_count+low_count (zero-extended, no overflow), meas_valid <= 1 for one cycle, prev_period <= new period, go to HIGH.
- Output latency: outputs update on the clock after the edge cycle, i.e. sync_stages+1 clk cycles after the sig_in transition.
- locked:
  - At each meas_valid, locked <= 1 if the new period equals prev_period and prev_period is non-zero; else locked <= 0.
  - The first meas_valid after IDLE never sets locked.
- Timeout:
  - In any state, if counter == timeout_value and no edge occurs this cycle: stuck <= 1, locked <= 0, state → IDLE.
  - high_count, low_count and period_count hold their last values. prev_period <= 0.
  - stuck clears on the next unmasked edge of either polarity.
- Simultaneous events:
  - An edge and the timeout on the same cycle: the edge wins and the timeout is not taken.
  - Reset mid-measurement discards the partial period with no meas_valid.
- Pulse limits: sig_in pulses shorter than one clk period may be missed. The minimum measurable high or low time is 1.

Test Plan:
- Drive sig_in from a clock divider with div_value=1 (toggles every 2 clk) → after the 2nd rise: high_count=2, low_count=2, period_count=4, meas_valid pulses once per 4 cycles, locked=1 from the 2nd meas_valid onward.
- Asymmetric input, high 5 / low 3 cycles → high_count=5, low_count=3, period_count=8, locked=1 after the second period.
- Period change from 8 to 10 cycles mid-run → the first 10-cycle meas_valid drops locked to 0, and the next one sets locked to 1.
- Override timeout_value=20; hold sig_in low 25 cycles after lock → stuck=1 and locked=0, with last counts retained. The next rise clears stuck and restarts from IDLE with no meas_valid until a full period is seen.
- sig_in held high through reset, then toggling → no meas_valid and no false rise during warm-up; the first valid measurement matches the true ratio.
- Assert rst while in LOW with counter=3 → all outputs 0 the next cycle, and no meas_valid for the aborted period.
